nfi_controller: RTL and testbench
=================================

Name: nfi_controller

Overview:
- Paces "next frame iteration" (NFI) steps of the Game-of-Life core.
- A free-running period counter makes a step due every MAX_CNT clock cycles.
- The step is issued as a one-cycle o_go pulse once the core reports it can accept a step (i_NFI_allowed) and the run is not paused.
- A user toggle-pause command freezes and resumes pacing; it sits between the UI/command decoder and the life-engine sequencer.

Parameters:
- MAX_CNT, default 10: frame period in clock cycles; must be >= 1. Counter width = max(1, $clog2(MAX_CNT)).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert / synchronous release (flops reset asynchronously), active-low.
- i_NFI_allowed  input  1  level; high = engine ready to accept a new iteration. Synchronous to clk.
- i_cmd_toggle_pause  input  1  pause-toggle command level; may be asynchronous to clk and may stay high for many cycles.
- o_go  output  1  registered one-cycle pulse requesting one frame iteration.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous) sets: counter=0, pending=0, paused=0 (running), synchronizer and edge-detect flops=0, o_go=0 immediately. Reset may assert at any time; all state is discarded.
- Command input path:
  - i_cmd_toggle_pause passes through a 2-flop synchronizer, then a rising-edge detector (third flop).
  - Each 0->1 transition toggles paused exactly once, 3 clock edges after the input rises (input stable >= 1 cycle).
  - Holding the input high produces no further toggles; falling edges are ignored.
- Period counter:
  - Increments by 1 on each edge when paused=0 and pending=0.
  - When counter==MAX_CNT-1 and it would increment, it wraps to 0 and sets pending=1 on the same edge.
  - Holds its value while paused=1 or pending=1.
  - MAX_CNT=1: pending sets on every advancing edge.
- Go logic, evaluated each edge:
  - o_go <= pending & i_NFI_allowed & ~paused.
  - When o_go is being set to 1, pending clears on the same edge.
  - o_go is therefore never high on two consecutive cycles.
  - The counter resumes counting on the edge after pending clears.
- With i_NFI_allowed=1 and no pause, the o_go period is MAX_CNT+1 cycles.
- pending while i_NFI_allowed=0: the step stays pending indefinitely with no loss and no double-issue. o_go fires on the first edge that samples i_NFI_allowed=1 (and paused=0).
- Pause while pending: pending is retained and o_go is suppressed. After unpause, o_go fires on the first edge with allowed=1.
- A toggle edge and a go condition on the same edge: the paused value before the edge governs o_go. The new paused value applies from the next edge.
- No other outputs; there is no overflow or error condition.

Test Plan:
- Timing convention: MAX_CNT=10, 10 ns clock, count edges from the first edge after rst_n rises.
- Free run: i_NFI_allowed=1, no pause -> pending sets at edge 10, o_go=1 only during cycle after edge 11, then again after edges 22, 33 (period 11, width 1).
- Allowed gating: i_NFI_allowed=0 for 40 cycles then 1 -> o_go stays 0, then exactly one pulse on the first edge sampling allowed=1, next pulse 11 cycles later.
- Pause: after first o_go, pulse i_cmd_toggle_pause high for 3 cycles -> paused 3 edges after rise, counter frozen, o_go=0 for 50 cycles. Second pulse -> resumes from frozen count; next o_go arrives in 11 minus cycles already counted.
- Pause while pending with allowed=0: set allowed=1 while paused -> no o_go. Unpause -> o_go 1 cycle after paused clears, single pulse.
- Long/async command: i_cmd_toggle_pause high 200 ns, changing mid-cycle -> exactly one toggle; release causes none.
- Reset mid-operation: assert rst_n=0 while o_go=1 -> o_go drops immediately without a clock. After release, first o_go again at edge 11, state running.

Source files
------------

// File: rtl/nfi_controller.sv
// Paces next-frame-iteration steps of the Game-of-Life core: a period counter
// makes a step pending every MAX_CNT cycles, issued as a one-cycle o_go when allowed.
module nfi_controller #(
    parameter int MAX_CNT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_NFI_allowed,
    input  logic i_cmd_toggle_pause,
    output logic o_go
);

    localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CNT - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             sync_p2;
    logic             toggle;
    logic             paused;
    logic             pending;
    logic [CNT_W-1:0] cnt;
    logic             advance;
    logic             wrap;
    logic             go_next;

    // The go term uses the pre-edge paused value, so a toggle landing on the
    // same edge only takes effect from the following edge.
    always_comb begin
        toggle  = sync_p1 & ~sync_p2;
        advance = ~paused & ~pending;
        wrap    = advance & (cnt == CNT_LAST);
        go_next = pending & i_NFI_allowed & ~paused;
    end

    // Stage p0/p1: command synchronizer; p2: edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= i_cmd_toggle_pause;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Pacing state and registered go pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paused  <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
            o_go    <= 1'b0;
        end else begin
            if (toggle) begin
                paused <= ~paused;
            end
            if (advance) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
            // Set and clear are mutually exclusive: set needs pending=0, clear needs pending=1.
            if (wrap) begin
                pending <= 1'b1;
            end else if (go_next) begin
                pending <= 1'b0;
            end
            o_go <= go_next;
        end
    end

endmodule

// File: tb/tb_nfi_controller.sv
// Bench for nfi_controller: scenario tasks plus randomized traffic, each compared
// against a behavioural pacing model kept in the bench.
module tb_nfi_controller;

    localparam int MAX_CNT = 10;

    logic clk;
    logic rst_n;
    logic allowed;
    logic cmd;
    logic go;

    int checks;
    int errors;

    // Behavioural model state
    int m_elapsed;
    bit m_pend;
    bit m_paused;
    bit m_go;
    bit m_hist[3];

    nfi_controller #(.MAX_CNT(MAX_CNT)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_NFI_allowed      (allowed),
        .i_cmd_toggle_pause (cmd),
        .o_go               (go)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_elapsed = 0;
        m_pend    = 0;
        m_paused  = 0;
        m_go      = 0;
        m_hist[0] = 0;
        m_hist[1] = 0;
        m_hist[2] = 0;
    endtask

    // One clock edge: model consumes inputs seen at the edge; returns 1 ns later.
    task automatic tick();
        bit a;
        bit c;
        bit tog;
        bit was_paused;
        bit was_pend;
        @(posedge clk);
        a = allowed;
        c = cmd;
        was_paused = m_paused;
        was_pend   = m_pend;
        // A command rise first seen at edge k toggles paused at edge k+2.
        tog = m_hist[1] & ~m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = c;
        m_go = was_pend & a & ~was_paused;
        if (!was_paused && !was_pend) begin
            m_elapsed++;
            if (m_elapsed == MAX_CNT) begin
                m_elapsed = 0;
                m_pend = 1;
            end
        end
        if (m_go) m_pend = 0;
        if (tog) m_paused = ~m_paused;
        #1;
    endtask

    // Leaves time at posedge+1 with reset released; the next edge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0;
        cmd   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        allowed = 1'b1;
        cmd = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL reset_async go=%b expected=0", go);
        end
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (go !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle edge=%0d go=%b expected=0", i, go);
            end
        end
    endtask

    task automatic test_free_run();
        bit exp;
        allowed = 1'b1;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp = (i == 11 || i == 22 || i == 33);
            checks++;
            if (go !== exp) begin
                errors++;
                $display("FAIL free_run edge=%0d go=%b expected=%b", i, go, exp);
            end
            checks++;
            if (go !== m_go) begin
                errors++;
                $display("FAIL free_run_model edge=%0d go=%b expected=%b", i, go, m_go);
            end
        end
    endtask

    task automatic test_allowed_gating();
        allowed = 1'b0;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (go !== 1'b0) begin
                errors++;
                $display("FAIL gating_hold edge=%0d go=%b expected=0", i, go);
            end
        end
        allowed = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (go !== (i == 1 || i == 12)) begin
                errors++;
                $display("FAIL gating_release tick=%0d go=%b expected=%b", i, go, (i == 1 || i == 12));
            end
        end
    endtask

    task automatic test_pause();
        int n;
        allowed = 1'b1;
        do_reset();
        repeat (11) tick();
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL pause_first_go go=%b expected=1", go);
        end
        cmd = 1'b1;
        repeat (3) tick();
        cmd = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (go !== 1'b0 || m_go !== 1'b0) begin
                errors++;
                $display("FAIL pause_frozen tick=%0d go=%b expected=0", i, go);
            end
        end
        cmd = 1'b1;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 3) cmd = 1'b0;
            checks++;
            if (go !== m_go) begin
                errors++;
                $display("FAIL pause_resume_model tick=%0d go=%b expected=%b", n, go, m_go);
            end
            if (go === 1'b1) break;
        end
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL pause_resume_latency ticks=%0d expected=11", n);
        end
    endtask

    task automatic test_pause_pending();
        int n;
        allowed = 1'b0;
        do_reset();
        repeat (10) tick();
        cmd = 1'b1;
        repeat (3) tick();
        cmd = 1'b0;
        repeat (2) tick();
        allowed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (go !== 1'b0) begin
                errors++;
                $display("FAIL pend_paused tick=%0d go=%b expected=0", i, go);
            end
        end
        cmd = 1'b1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (n == 3) cmd = 1'b0;
            if (go === 1'b1) break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL pend_unpause_latency ticks=%0d expected=4", n);
        end
        if (n < 3) cmd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (go !== 1'b0) begin
                errors++;
                $display("FAIL pend_single_pulse tick=%0d go=%b expected=0", i, go);
            end
        end
    endtask

    task automatic test_async_cmd();
        allowed = 1'b1;
        do_reset();
        repeat (11) tick();
        fork
            begin
                #123 cmd = 1'b1;
                #200 cmd = 1'b0;
            end
        join_none
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (go !== m_go) begin
                errors++;
                $display("FAIL async_model tick=%0d go=%b expected=%b", i, go, m_go);
            end
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (go !== 1'b0) begin
                errors++;
                $display("FAIL async_single_toggle tick=%0d go=%b expected=0", i, go);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        allowed = 1'b1;
        do_reset();
        n = 0;
        while (go !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reach go=%b expected=1", go);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drop go=%b expected=0", go);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (go === 1'b1) break;
        end
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL reset_mid_first_go ticks=%0d expected=11", n);
        end
    endtask

    task automatic test_random();
        allowed = 1'b1;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            allowed = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 14) == 0) cmd = ~cmd;
            tick();
            checks++;
            if (go !== m_go) begin
                errors++;
                $display("FAIL random tick=%0d go=%b expected=%b", i, go, m_go);
            end
        end
        cmd = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        allowed = 1'b0;
        cmd     = 1'b0;
        model_reset();
        test_reset();
        test_free_run();
        test_allowed_gating();
        test_pause();
        test_pause_pending();
        test_async_cmd();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
